// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: PC operation codes, FSM states
// and the default reset vector.
package pc_defs;

  // Decoded PC operation; 3'b110 and 3'b111 are unused and behave as PC_SEQ.
  typedef enum logic [2:0] {
    PC_SEQ = 3'b000,
    PC_BEQ = 3'b001,
    PC_BNE = 3'b010,
    PC_J   = 3'b011,
    PC_JR  = 3'b100,
    PC_JAL = 3'b101
  } pc_op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake. The sequencer is the master: it raises
// imem_req with imem_addr, and the memory answers with imem_ack.
interface pc_sequencer_if;

  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_addr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );

endinterface

// File: rtl/pc_sequencer_next.sv
// Combinational next-PC selection. Reports whether a non-sequential path was
// selected (taken) and whether a JR target is not word aligned (misalign).
module pc_next
  import pc_defs::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [2:0]  pc_op,
  input  logic        zero_flag,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  input  logic [31:0] rs_value,
  output logic [31:0] next_pc,
  output logic        taken,
  output logic        misalign
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Branch offset is in words; the shift drops the top two bits, which is the
  // intended modulo-2^32 behaviour.
  assign branch_target = pc_plus4 + (imm_ext << 2);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  // Select the target for the decoded operation; taken flags any non-seq pick.
  always_comb begin
    next_pc  = pc_plus4;
    taken    = 1'b0;
    misalign = 1'b0;
    case (pc_op)
      PC_BEQ: begin
        if (zero_flag) begin
          taken   = 1'b1;
          next_pc = branch_target;
        end
      end
      PC_BNE: begin
        if (!zero_flag) begin
          taken   = 1'b1;
          next_pc = branch_target;
        end
      end
      PC_J, PC_JAL: begin
        taken   = 1'b1;
        next_pc = jump_target;
      end
      PC_JR: begin
        taken    = 1'b1;
        next_pc  = rs_value;
        misalign = (rs_value[1:0] != 2'b00);
      end
      default: begin
        next_pc = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: owns the PC, fetches through the imem handshake
// and applies the decoded PC operation once the instruction is executed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request instruction at pc; leave on accepted handshake
// ST_EXEC  | wait for valid decode without stall; update pc or halt
// ST_HALT  | JR target was misaligned; idle until reset
module pc_sequencer
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           pc_op,
  input  logic                 zero_flag,
  input  logic [31:0]          imm_ext,
  input  logic [25:0]          jump_index,
  input  logic [31:0]          rs_value,
  input  logic                 instr_valid,
  input  logic                 stall,
  pc_sequencer_if.master       bus,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 link_we,
  output logic [31:0]          link_data,
  output logic                 redirect,
  output logic                 misaligned
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_plus4_c;
  logic [31:0] nx_pc;
  logic        nx_taken;
  logic        nx_misalign;
  logic        exec_go;
  logic        imem_req_c;
  logic        link_we_c;
  logic        redirect_c;

  assign pc_plus4_c = pc_q + 32'd4;

  pc_next u_pc_next (
    .pc_plus4   (pc_plus4_c),
    .pc_op      (pc_op),
    .zero_flag  (zero_flag),
    .imm_ext    (imm_ext),
    .jump_index (jump_index),
    .rs_value   (rs_value),
    .next_pc    (nx_pc),
    .taken      (nx_taken),
    .misalign   (nx_misalign)
  );

  // Reset gates the execute qualifier so an instruction in flight is dropped.
  assign exec_go = (state_q == ST_EXEC) && !stall && instr_valid && !reset;

  // Next-state, PC update and the combinational request/pulse outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    imem_req_c   = 1'b0;
    link_we_c    = 1'b0;
    redirect_c   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = !stall && !reset;
        if (imem_req_c && bus.imem_ack) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_go) begin
          if ((pc_op == PC_JR) && nx_misalign) begin
            // Bad JR target: keep pc pointing at the offending instruction.
            misaligned_d = 1'b1;
            state_d      = ST_HALT;
          end else begin
            pc_d       = nx_pc;
            state_d    = ST_FETCH;
            redirect_c = nx_taken;
            link_we_c  = (pc_op == PC_JAL);
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // FSM state, PC and sticky halt flag; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.imem_req  = imem_req_c;
  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_c;
  assign link_we       = link_we_c;
  assign link_data     = pc_plus4_c;
  assign redirect      = redirect_c;
  assign misaligned    = misaligned_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the MIPS core. Owns the PC register, fetches instructions through a request/acknowledge handshake to instruction memory, and applies the decoded PC operation (sequential, BEQ, BNE, J, JR, JAL) to select the next PC. Sits between the control unit, the ALU zero flag and the instruction memory. Replaces the purely combinational PC-source selection with a sequenced fetch/execute loop that supports stall and a sticky misaligned-target halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- pc_op  in  3  000 seq, 001 BEQ, 010 BNE, 011 J, 100 JR, 101 JAL; 110/111 treated as seq
- zero_flag  in  1  ALU zero result for the current instruction
- imm_ext  in  32  sign-extended 16-bit branch offset (word units)
- jump_index  in  26  instr[25:0]
- rs_value  in  32  register rs contents (JR target)
- instr_valid  in  1  decode fields valid this cycle
- stall  in  1  hold current state; no PC update, no fetch request
- imem_ack  in  1  instruction memory accepted the request
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, always equal to pc
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4
- link_we  out  1  one-cycle pulse: write link_data to $31
- link_data  out  32  return address, equals pc_plus4
- redirect  out  1  one-cycle pulse: non-sequential PC taken
- misaligned  out  1  sticky: JR target not word-aligned; core halted

## Operation
- States: FETCH, EXEC, HALT. Reset -> FETCH.
- FETCH: imem_req = !stall. Transition to EXEC when imem_req && imem_ack. With stall high, imem_req = 0 and imem_ack is ignored.
- EXEC: wait while stall || !instr_valid. Otherwise, compute next PC, load pc and go to FETCH.
  - seq: pc_plus4.
  - BEQ: taken if zero_flag. BNE: taken if !zero_flag. Taken target = pc_plus4 + (imm_ext << 2); not taken = pc_plus4.
  - J/JAL: {pc_plus4[31:28], jump_index, 2'b00}.
  - JR: rs_value.
- link_we (combinational) = EXEC && !stall && instr_valid && pc_op==JAL. link_data = pc_plus4 of the JAL.
- redirect (combinational) = same qualifier && next PC is not pc_plus4 by selection. Taken branch to pc_plus4 (imm 0) still asserts redirect.
- JR with rs_value[1:0] != 0: pc unchanged, misaligned <= 1, go to HALT.
- HALT: no requests, all pulses 0. Exit only by reset.
- Arithmetic: all 32-bit, modulo 2^32. pc 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap naturally.
- Branch/jump targets are always aligned. Only JR is checked.

## Timing
- Reset values: pc = RESET_PC, state = FETCH, misaligned = 0. While reset is high, imem_req, link_we and redirect are all 0 (gated by reset).
- First imem_req is asserted in the cycle after reset deasserts.
- Minimum 2 cycles per instruction: ack in cycle N, EXEC in N+1, new pc visible in N+2 with imem_req high.
- pc changes only on the EXEC->FETCH edge or on reset.
- Stall in EXEC freezes all state and suppresses pulses. Stall is honoured on the same cycle.
- Reset asserted mid-EXEC (even with instr_valid) discards the instruction: no link_we, and pc = RESET_PC next cycle.
- imem_ack while not in FETCH is ignored.

## Structure
- Package pc_defs holds:
  - PCOp encodings (PC_SEQ, PC_BEQ, PC_BNE, PC_J, PC_JR, PC_JAL)
  - state encoding (ST_FETCH, ST_EXEC, ST_HALT)
  - default RESET_PC
- Sub-module pc_next: combinational next-PC/target mux. Inputs pc_plus4, pc_op, zero_flag, imm_ext, jump_index, rs_value. Outputs next_pc, taken, misalign.
- Top-level holds the FSM, PC register and the handshake logic.

## Test plan
- Reset, then seq op with immediate ack: imem_addr 0, then 4, then 8; imem_req high every other cycle; redirect never asserts.
- pc=0x100, BEQ, zero_flag=1, imm_ext=0xFFFF_FFFF -> pc=0x100, redirect=1. Same with zero_flag=0 -> pc=0x104, redirect=0. BNE gives the mirror results.
- pc=0x0040_0010, JAL, jump_index=0x0000040 -> link_we pulse with link_data=0x0040_0014, then pc=0x0000_0100.
- JR rs_value=0x0000_2002 -> misaligned=1, pc unchanged, imem_req stays 0 forever; reset clears misaligned and restores RESET_PC.
- Stall for 3 cycles in EXEC with instr_valid=1 and JAL -> no link_we until stall drops, then exactly one pulse. Ack held off 4 cycles in FETCH -> pc stable.
- pc=0xFFFF_FFFC, seq op -> pc=0x0000_0000. Reset in EXEC cycle with JAL -> no link_we, pc=RESET_PC.
